// File: rtl/counter_mod_prescaled.sv
// ============================================================================
// Module      : counter_mod_prescaled
// Description : Modulo-N up/down counter with prescaler, clear, load, tc/wrap.
//               Define COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module counter_mod_prescaled #(
  parameter int unsigned     WIDTH    = 32,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 64'd1);
  localparam int unsigned      c_PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;
  logic             w_step;
  logic             w_at_end;

  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign w_step = en;
    end else begin : g_prescale
      localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);
      logic [c_PW-1:0] r_pre;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pre <= '0;
        end else if (clr || load) begin
          r_pre <= '0;
        end else if (en) begin
          r_pre <= (r_pre == c_PRE_LAST) ? '0 : r_pre + c_PW'(1);
        end
      end

      assign w_step = en && (r_pre == c_PRE_LAST);
    end
  endgenerate

  // The terminal value depends on direction, so tc reacts to up_dn at once.
  assign w_at_end   = up_dn ? (r_count == c_MAX) : (r_count == '0);
  assign tc         = w_at_end;
  assign count      = r_count;
  assign w_load_val = (64'(load_val) > (MODULUS - 64'd1)) ? c_MAX : load_val;

  always_comb begin
    w_next = r_count;
    if (up_dn) begin
`ifdef COUNTER_SATURATE_EN
      w_next = w_at_end ? c_MAX : r_count + WIDTH'(1);
`else
      w_next = w_at_end ? '0 : r_count + WIDTH'(1);
`endif
    end else begin
`ifdef COUNTER_SATURATE_EN
      w_next = w_at_end ? '0 : r_count - WIDTH'(1);
`else
      w_next = w_at_end ? c_MAX : r_count - WIDTH'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= w_load_val;
    end else if (w_step) begin
      r_count <= w_next;
    end
  end

`ifdef COUNTER_SATURATE_EN
  assign wrap = 1'b0;
`else
  logic r_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= !clr && !load && w_step && w_at_end;
    end
  end

  assign wrap = r_wrap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_mod_prescaled.sv
// Bench for counter_mod_prescaled: PRESCALE=1 and PRESCALE=3 instances (WIDTH=8, MODULUS=10)
// driven with shared inputs and compared against an arithmetic reference model.
`default_nettype none

module tb_counter_mod_prescaled;
  localparam int MOD = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, clr = 1'b0, load = 1'b0, up_dn = 1'b1;
  logic [7:0] load_val = 8'd0;
  logic [7:0] cnt1, cnt3;
  logic       tc1, tc3, wr1, wr3;

  int checks = 0;
  int failures = 0;
  int m_cnt[2];
  int m_pre[2];
  int m_wrap[2];
  int psc[2] = '{1, 3};

  always #5 clk = ~clk;

  counter_mod_prescaled #(.WIDTH(8), .MODULUS(MOD), .PRESCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn), .count(cnt1), .tc(tc1), .wrap(wr1));

  counter_mod_prescaled #(.WIDTH(8), .MODULUS(MOD), .PRESCALE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn), .count(cnt3), .tc(tc3), .wrap(wr3));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_tc(input int k);
    return up_dn ? int'(m_cnt[k] == MOD - 1) : int'(m_cnt[k] == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 0;
      if (clr) begin
        m_cnt[k] = 0; m_pre[k] = 0;
      end else if (load) begin
        m_cnt[k] = (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
        m_pre[k] = 0;
      end else if (en) begin
        if (m_pre[k] == psc[k] - 1) begin
          bit boundary;
          m_pre[k] = 0;
          boundary = up_dn ? (m_cnt[k] == MOD - 1) : (m_cnt[k] == 0);
`ifdef COUNTER_SATURATE_EN
          if (!boundary) m_cnt[k] = m_cnt[k] + (up_dn ? 1 : -1);
`else
          m_cnt[k] = (m_cnt[k] + (up_dn ? 1 : MOD - 1)) % MOD;
          m_wrap[k] = int'(boundary);
`endif
        end else begin
          m_pre[k] = m_pre[k] + 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "_cnt1"}, 32'(cnt1), 32'(m_cnt[0]));
    check_val({tag, "_wrap1"}, 32'(wr1), 32'(m_wrap[0]));
    check_val({tag, "_tc1"}, 32'(tc1), 32'(m_tc(0)));
    check_val({tag, "_cnt3"}, 32'(cnt3), 32'(m_cnt[1]));
    check_val({tag, "_wrap3"}, 32'(wr3), 32'(m_wrap[1]));
    check_val({tag, "_tc3"}, 32'(tc3), 32'(m_tc(1)));
  endtask

  // Inputs change at posedge+1; tc is checked before the edge, state after it.
  task automatic cycle(input logic e, input logic c, input logic l, input logic u,
                       input logic [7:0] lv, input string tag);
    en = e; clr = c; load = l; up_dn = u; load_val = lv;
    #1;
    check_val({tag, "_pre_tc1"}, 32'(tc1), 32'(m_tc(0)));
    check_val({tag, "_pre_tc3"}, 32'(tc3), 32'(m_tc(1)));
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Up count over 12 enabled cycles
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, "up12");
`ifndef COUNTER_SATURATE_EN
      check_val("up12_seq", 32'(cnt1), 32'((i + 1) % MOD));
      check_val("up12_wrap", 32'(wr1), 32'(i == 9));
`endif
    end

    // Prescaler: en pattern 1,1,0,1 after clear
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, "clr");
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, "ps_a");
    check_val("ps_a_cnt3", 32'(cnt3), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, "ps_b");
    check_val("ps_b_cnt3", 32'(cnt3), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, "ps_c");
    check_val("ps_c_cnt3", 32'(cnt3), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, "ps_d");
    check_val("ps_d_cnt3", 32'(cnt3), 32'd1);

    // Down from 0, then saturating and in-range loads
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "clr2");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "down0");
`ifndef COUNTER_SATURATE_EN
    check_val("down0_cnt1", 32'(cnt1), 32'd9);
    check_val("down0_wrap1", 32'(wr1), 32'd1);
`endif
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'd200, "ld200");
    check_val("ld200_cnt1", 32'(cnt1), 32'd9);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'd4, "ld4");
    check_val("ld4_cnt3", 32'(cnt3), 32'd4);

    // clr beats load and step
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'd9, "ld9");
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'd5, "clrwin");
    check_val("clrwin_cnt1", 32'(cnt1), 32'd0);
    check_val("clrwin_wrap1", 32'(wr1), 32'd0);

    // Async reset mid-count at 7
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'd7, "ld7");
    do_reset("arst");

    // Randomized traffic with occasional async reset
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        cycle($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 4,
              $urandom_range(0, 99) < 7, $urandom_range(0, 9) < 6,
              8'($urandom_range(0, 255)), "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
